// File: rtl/hilo_muldiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hilo_muldiv_ctrl_pkg
// Purpose : Shared definitions for the HI/LO multiply/divide sequencer:
//           operation encodings, controller states, iteration constants
//           and small operation-decode helpers.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package hilo_muldiv_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int ITER_LAST      = DEF_DATA_WIDTH - 1;

  // Operation encodings as presented by the EX stage on Op[1:0]
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  // Controller states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : hilo_muldiv_ctrl_if
// Purpose : Pipeline-side bundle of the HI/LO multiply/divide resource.
// Ports   : master (EX stage): drives Start/Op/A/B, ReadHiLo, WriteHi,
//           WriteLo, WriteData; receives HI/LO, Busy, Stall, Done,
//           DivByZero.
//           slave (hilo_muldiv_ctrl): the reverse directions.
// Revision: 1.0 - initial release
// ============================================================================
interface hilo_muldiv_ctrl_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  Start;
  logic [1:0]            Op;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  ReadHiLo;
  logic                  WriteHi;
  logic                  WriteLo;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] HI;
  logic [DATA_WIDTH-1:0] LO;
  logic                  Busy;
  logic                  Stall;
  logic                  Done;
  logic                  DivByZero;

  modport master (
    output Start, Op, A, B, ReadHiLo, WriteHi, WriteLo, WriteData,
    input  HI, LO, Busy, Stall, Done, DivByZero
  );

  modport slave (
    input  Start, Op, A, B, ReadHiLo, WriteHi, WriteLo, WriteData,
    output HI, LO, Busy, Stall, Done, DivByZero
  );

endinterface
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl_step.sv
`default_nettype none
// ============================================================================
// Module  : hilo_muldiv_ctrl_step
// Purpose : Combinational single-iteration datapath shared by the multiply
//           and divide sequences.
//           Multiply: {acc, mq} holds the growing product; mq[0] selects
//           whether the operand is added before the pair shifts right.
//           Divide  : {acc, mq} holds remainder/dividend; the pair shifts
//           left, the operand is trial-subtracted from the 33-bit partial
//           remainder and the quotient bit enters mq[0].
// Ports   : acc_i/mq_i   current accumulator/remainder and shift register
//           opnd_i       multiplicand or divisor magnitude
//           is_div_i     1 = restoring divide step, 0 = shift-add step
//           acc_o/mq_o   values after the step
// Revision: 1.0 - initial release
// ============================================================================
module hilo_muldiv_ctrl_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] acc_i,
  input  logic [DATA_WIDTH-1:0] mq_i,
  input  logic [DATA_WIDTH-1:0] opnd_i,
  input  logic                  is_div_i,
  output logic [DATA_WIDTH-1:0] acc_o,
  output logic [DATA_WIDTH-1:0] mq_o
);

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] rem_sh;
  logic                ge;

  always_comb begin
    // Carry out of the add lands in the MSB and is shifted straight back in.
    sum    = {1'b0, acc_i} + (mq_i[0] ? {1'b0, opnd_i} : '0);
    // The partial remainder is one bit wider than the divisor, so the
    // shifted value never overflows before the compare.
    rem_sh = {acc_i, mq_i[DATA_WIDTH-1]};
    ge     = (rem_sh >= {1'b0, opnd_i});

    if (is_div_i) begin
      acc_o = ge ? DATA_WIDTH'(rem_sh - {1'b0, opnd_i}) : rem_sh[DATA_WIDTH-1:0];
      mq_o  = {mq_i[DATA_WIDTH-2:0], ge};
    end else begin
      acc_o = sum[DATA_WIDTH:1];
      mq_o  = {sum[0], mq_i[DATA_WIDTH-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hilo_muldiv_ctrl
// Purpose : Sequencer for the HI/LO multiply/divide resource of the MIPS
//           pipeline. Runs MULT/MULTU/DIV/DIVU as a fixed 33-cycle sequence
//           (32 iteration steps plus one sign-fix cycle), owns HI and LO,
//           performs MTHI/MTLO writes and requests pipeline stalls while a
//           result is pending.
// Ports   : Clk    core clock, rising edge
//           Reset  asynchronous, active-low reset
//           bus    hilo_muldiv_ctrl_if.slave
//                  in : Start, Op, A, B, ReadHiLo, WriteHi, WriteLo,
//                       WriteData
//                  out: HI, LO, Busy, Stall (combinational), Done,
//                       DivByZero
// Revision: 1.0 - initial release
// ============================================================================
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic              Clk,
  input  logic              Reset,
  hilo_muldiv_ctrl_if.slave bus
);

  localparam int                    CW       = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]         CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

  // ---------------------------------------------------------------- state
  state_e                state_q,   state_d;
  op_e                   op_q,      op_d;
  logic [CW-1:0]         cnt_q,     cnt_d;
  logic [DATA_WIDTH-1:0] acc_q,     acc_d;
  logic [DATA_WIDTH-1:0] mq_q,      mq_d;
  logic [DATA_WIDTH-1:0] opnd_q,    opnd_d;
  logic                  neg_res_q, neg_res_d;   // product / quotient sign
  logic                  neg_rem_q, neg_rem_d;   // dividend sign
  logic                  div0_q,    div0_d;      // divide with B == 0
  logic [DATA_WIDTH-1:0] hi_q,      hi_d;
  logic [DATA_WIDTH-1:0] lo_q,      lo_d;
  logic                  busy_q,    busy_d;
  logic                  done_q,    done_d;
  logic                  dbz_q,     dbz_d;

  // ------------------------------------------------------ operand decode
  op_e                   start_op;
  logic                  start_signed;
  logic                  a_neg;
  logic                  b_neg;
  logic [DATA_WIDTH-1:0] a_mag;
  logic [DATA_WIDTH-1:0] b_mag;

  always_comb begin
    start_op     = op_e'(bus.Op);
    start_signed = op_is_signed(start_op);
    a_neg        = start_signed & bus.A[DATA_WIDTH-1];
    b_neg        = start_signed & bus.B[DATA_WIDTH-1];
    // Negating the most negative value yields the same bit pattern, which
    // is exactly its unsigned magnitude.
    a_mag        = a_neg ? -bus.A : bus.A;
    b_mag        = b_neg ? -bus.B : bus.B;
  end

  // ------------------------------------------------------ iteration step
  logic                  step_is_div;
  logic [DATA_WIDTH-1:0] step_acc;
  logic [DATA_WIDTH-1:0] step_mq;

  assign step_is_div = op_is_div(op_q);

  hilo_muldiv_ctrl_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .acc_i    (acc_q),
    .mq_i     (mq_q),
    .opnd_i   (opnd_q),
    .is_div_i (step_is_div),
    .acc_o    (step_acc),
    .mq_o     (step_mq)
  );

  // ------------------------------------------------------ sign correction
  logic [2*DATA_WIDTH-1:0] prod_mag;
  logic [2*DATA_WIDTH-1:0] prod_fix;
  logic [DATA_WIDTH-1:0]   quot_fix;
  logic [DATA_WIDTH-1:0]   rem_fix;

  always_comb begin
    prod_mag = {acc_q, mq_q};
    prod_fix = neg_res_q ? -prod_mag : prod_mag;
    // Divide by zero leaves an all-ones quotient regardless of signs; the
    // remainder then equals |A| and regains A's sign, which reproduces A.
    quot_fix = div0_q ? ALL_ONES : (neg_res_q ? -mq_q : mq_q);
    rem_fix  = neg_rem_q ? -acc_q : acc_q;
  end

  // ------------------------------------------------------ next-state logic
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          // Start wins over a same-cycle MTHI/MTLO; the write is dropped.
          op_d      = start_op;
          acc_d     = '0;
          mq_d      = a_mag;
          opnd_d    = b_mag;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = op_is_div(start_op) && (bus.B == '0);
          cnt_d     = CNT_LAST;
          busy_d    = 1'b1;
          state_d   = S_RUN;
        end else begin
          if (bus.WriteHi) hi_d = bus.WriteData;
          if (bus.WriteLo) lo_d = bus.WriteData;
        end
      end

      S_RUN: begin
        acc_d = step_acc;
        mq_d  = step_mq;
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_FIX: begin
        if (op_is_div(op_q)) begin
          lo_d = quot_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
          lo_d = prod_fix[DATA_WIDTH-1:0];
        end
        done_d  = 1'b1;
        dbz_d   = div0_q;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------ registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MULT;
      cnt_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  // ------------------------------------------------------ outputs
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.DivByZero = dbz_q;
  // Any instruction touching the resource is frozen in EX until the first
  // IDLE cycle, where it is then acted on.
  assign bus.Stall     = busy_q & (bus.Start | bus.ReadHiLo | bus.WriteHi | bus.WriteLo);

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hilo_muldiv_ctrl
// Purpose : Self-checking bench for hilo_muldiv_ctrl. Directed vectors,
//           randomized operations against an arithmetic reference model,
//           MTHI/MTLO, stall, reset-abort and busy-restart scenarios.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv_ctrl;

  logic Clk = 1'b0;
  logic Reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 Clk = ~Clk;

  hilo_muldiv_ctrl_if #(.DATA_WIDTH(32)) bus_if ();

  hilo_muldiv_ctrl #(.DATA_WIDTH(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_if)
  );

  // Reference: {DivByZero, HI, LO} from plain 64-bit arithmetic.
  function automatic logic [64:0] ref_model(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    if (op == 2'b00) begin
      p = sa * sb;
      return {1'b0, p};
    end else if (op == 2'b01) begin
      p = ua * ub;
      return {1'b0, p};
    end else if (b == 32'd0) begin
      return {1'b1, a, 32'hFFFF_FFFF};
    end else if (op == 2'b10) begin
      sq = sa / sb;
      sr = sa % sb;
      return {1'b0, sr[31:0], sq[31:0]};
    end
    uq = ua / ub;
    ur = ua % ub;
    return {1'b0, ur[31:0], uq[31:0]};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issues one operation (called just after a falling edge) and returns
  // what was observed; the caller does the comparisons.
  task automatic run_op(input  logic [1:0]  op,
                        input  logic [31:0] a,
                        input  logic [31:0] b,
                        output logic [31:0] hi,
                        output logic [31:0] lo,
                        output logic        dbz,
                        output int          lat,
                        output bit          busy_ok,
                        output bit          pulse_ok);
    bus_if.Start = 1'b1;
    bus_if.Op    = op;
    bus_if.A     = a;
    bus_if.B     = b;
    @(posedge Clk);
    @(negedge Clk);
    bus_if.Start = 1'b0;
    bus_if.A     = $urandom;
    bus_if.B     = $urandom;
    lat     = 0;
    busy_ok = 1'b1;
    while (bus_if.Done !== 1'b1 && lat < 40) begin
      if (bus_if.Busy !== 1'b1) busy_ok = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      lat++;
    end
    hi  = bus_if.HI;
    lo  = bus_if.LO;
    dbz = bus_if.DivByZero;
    if (bus_if.Busy !== 1'b0) busy_ok = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    pulse_ok = (bus_if.Done === 1'b0) && (bus_if.DivByZero === 1'b0);
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if ({bus_if.HI, bus_if.LO} !== 64'd0) begin
      failures++;
      $display("FAIL reset_hilo: got %h expected 0", {bus_if.HI, bus_if.LO});
    end
    checks++;
    if ({bus_if.Busy, bus_if.Stall, bus_if.Done, bus_if.DivByZero} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 0000",
               {bus_if.Busy, bus_if.Stall, bus_if.Done, bus_if.DivByZero});
    end
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    checks++;
    if (bus_if.Busy !== 1'b0 || bus_if.Done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle: busy=%b done=%b expected 0 0", bus_if.Busy, bus_if.Done);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  d_op  [9];
    logic [31:0] d_a   [9];
    logic [31:0] d_b   [9];
    logic [31:0] d_hi  [9];
    logic [31:0] d_lo  [9];
    logic        d_dbz [9];
    logic [31:0] hi, lo;
    logic        dbz;
    int          lat;
    bit          busy_ok, pulse_ok;
    d_op  = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b00, 2'b10, 2'b11};
    d_a   = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7,
              32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'd100};
    d_b   = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd0,
              32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd7};
    d_hi  = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'd7,
              32'd0, 32'h4000_0000, 32'hFFFF_FFF9, 32'd2};
    d_lo  = '{32'hFFFF_FFF1, 32'h0000_0001, 32'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
              32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd14};
    d_dbz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], hi, lo, dbz, lat, busy_ok, pulse_ok);
      checks++;
      if (lat !== 33) begin
        failures++;
        $display("FAIL directed_latency[%0d]: got %0d expected 33", i, lat);
      end
      checks++;
      if (!busy_ok) begin
        failures++;
        $display("FAIL directed_busy[%0d]: got busy gap expected busy through E33 only", i);
      end
      checks++;
      if ({hi, lo} !== {d_hi[i], d_lo[i]}) begin
        failures++;
        $display("FAIL directed_result[%0d]: got %h_%h expected %h_%h", i, hi, lo, d_hi[i], d_lo[i]);
      end
      checks++;
      if (dbz !== d_dbz[i] || !pulse_ok) begin
        failures++;
        $display("FAIL directed_flags[%0d]: got dbz=%b one_cycle=%b expected dbz=%b one_cycle=1",
                 i, dbz, pulse_ok, d_dbz[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
    logic [64:0] exp;
    int          lat;
    bit          busy_ok, pulse_ok;
    for (int i = 0; i < 24; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = pick_operand();
      b   = pick_operand();
      exp = ref_model(op, a, b);
      run_op(op, a, b, hi, lo, dbz, lat, busy_ok, pulse_ok);
      checks++;
      if ({dbz, hi, lo} !== exp || lat !== 33 || !busy_ok || !pulse_ok) begin
        failures++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got dbz=%b %h_%h lat=%0d expected dbz=%b %h_%h lat=33",
                 i, op, a, b, dbz, hi, lo, lat, exp[64], exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_mthi_mtlo();
    int n;
    bus_if.WriteHi   = 1'b1;
    bus_if.WriteData = 32'h1234_5678;
    @(negedge Clk);
    bus_if.WriteHi = 1'b0;
    checks++;
    if (bus_if.HI !== 32'h1234_5678) begin
      failures++;
      $display("FAIL mthi: got %h expected 12345678", bus_if.HI);
    end
    bus_if.WriteLo   = 1'b1;
    bus_if.WriteData = 32'hCAFE_F00D;
    @(negedge Clk);
    bus_if.WriteLo = 1'b0;
    checks++;
    if ({bus_if.HI, bus_if.LO} !== {32'h1234_5678, 32'hCAFE_F00D}) begin
      failures++;
      $display("FAIL mtlo: got %h_%h expected 12345678_cafef00d", bus_if.HI, bus_if.LO);
    end
    // Start together with MTHI: the write is dropped.
    bus_if.Start     = 1'b1;
    bus_if.Op        = 2'b01;
    bus_if.A         = 32'd2;
    bus_if.B         = 32'd3;
    bus_if.WriteHi   = 1'b1;
    bus_if.WriteData = 32'hDEAD_BEEF;
    @(negedge Clk);
    bus_if.Start   = 1'b0;
    bus_if.WriteHi = 1'b0;
    checks++;
    if (bus_if.HI !== 32'h1234_5678 || bus_if.Busy !== 1'b1) begin
      failures++;
      $display("FAIL start_beats_mthi: got hi=%h busy=%b expected hi=12345678 busy=1", bus_if.HI, bus_if.Busy);
    end
    n = 0;
    while (bus_if.Done !== 1'b1 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if ({bus_if.HI, bus_if.LO} !== {32'd0, 32'd6} || n !== 33) begin
      failures++;
      $display("FAIL start_beats_mthi_result: got %h_%h after %0d expected 00000000_00000006 after 33",
               bus_if.HI, bus_if.LO, n);
    end
    @(negedge Clk);
  endtask

  task automatic test_stall_read();
    int n;
    bit stall_ok;
    bus_if.Start = 1'b1;
    bus_if.Op    = 2'b11;
    bus_if.A     = 32'd100;
    bus_if.B     = 32'd7;
    @(negedge Clk);
    bus_if.Start = 1'b0;
    #1;
    checks++;
    if (bus_if.Stall !== 1'b0) begin
      failures++;
      $display("FAIL stall_idle_request: got %b expected 0", bus_if.Stall);
    end
    @(negedge Clk);
    bus_if.ReadHiLo = 1'b1;
    #1;
    n        = 0;
    stall_ok = 1'b1;
    while (bus_if.Done !== 1'b1 && n < 40) begin
      if (bus_if.Stall !== 1'b1) stall_ok = 1'b0;
      @(negedge Clk);
      #1;
      n++;
    end
    checks++;
    if (!stall_ok || n !== 32) begin
      failures++;
      $display("FAIL stall_hold: got ok=%b cycles=%0d expected ok=1 cycles=32", stall_ok, n);
    end
    checks++;
    if (bus_if.Stall !== 1'b0) begin
      failures++;
      $display("FAIL stall_release: got %b expected 0 in Done cycle", bus_if.Stall);
    end
    checks++;
    if ({bus_if.HI, bus_if.LO} !== {32'd2, 32'd14}) begin
      failures++;
      $display("FAIL divu_100_7: got %h_%h expected 00000002_0000000e", bus_if.HI, bus_if.LO);
    end
    bus_if.ReadHiLo = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset_abort();
    logic [31:0] hi, lo;
    logic        dbz;
    int          lat;
    bit          busy_ok, pulse_ok;
    bus_if.Start = 1'b1;
    bus_if.Op    = 2'b01;
    bus_if.A     = 32'd3;
    bus_if.B     = 32'd4;
    @(negedge Clk);
    bus_if.Start = 1'b0;
    repeat (9) @(negedge Clk);
    checks++;
    if (bus_if.Busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_midop_busy: got %b expected 1", bus_if.Busy);
    end
    Reset = 1'b0;
    #1;
    checks++;
    if ({bus_if.HI, bus_if.LO} !== 64'd0 || bus_if.Busy !== 1'b0 || bus_if.Done !== 1'b0) begin
      failures++;
      $display("FAIL abort_clear: got %h_%h busy=%b done=%b expected 0_0 busy=0 done=0",
               bus_if.HI, bus_if.LO, bus_if.Busy, bus_if.Done);
    end
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    run_op(2'b01, 32'd3, 32'd4, hi, lo, dbz, lat, busy_ok, pulse_ok);
    checks++;
    if ({hi, lo} !== {32'd0, 32'd12} || lat !== 33 || !busy_ok || dbz !== 1'b0) begin
      failures++;
      $display("FAIL abort_rerun: got %h_%h lat=%0d expected 00000000_0000000c lat=33", hi, lo, lat);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit idle_ok;
    bus_if.Start = 1'b1;
    bus_if.Op    = 2'b01;
    bus_if.A     = 32'h0001_2345;
    bus_if.B     = 32'h0000_0100;
    @(negedge Clk);
    bus_if.Start = 1'b0;
    repeat (4) @(negedge Clk);
    bus_if.Start = 1'b1;
    bus_if.Op    = 2'b11;
    bus_if.A     = 32'd9;
    bus_if.B     = 32'd3;
    #1;
    checks++;
    if (bus_if.Stall !== 1'b1) begin
      failures++;
      $display("FAIL busy_start_stall: got %b expected 1", bus_if.Stall);
    end
    @(negedge Clk);
    bus_if.Start = 1'b0;
    n = 5;
    while (bus_if.Done !== 1'b1 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if ({bus_if.HI, bus_if.LO} !== {32'd0, 32'h0123_4500} || n !== 33) begin
      failures++;
      $display("FAIL busy_start_first_wins: got %h_%h after %0d expected 00000000_01234500 after 33",
               bus_if.HI, bus_if.LO, n);
    end
    idle_ok = 1'b1;
    repeat (40) begin
      @(negedge Clk);
      if (bus_if.Busy !== 1'b0 || bus_if.Done !== 1'b0) idle_ok = 1'b0;
    end
    checks++;
    if (!idle_ok || bus_if.LO !== 32'h0123_4500) begin
      failures++;
      $display("FAIL busy_start_not_captured: got idle=%b lo=%h expected idle=1 lo=01234500",
               idle_ok, bus_if.LO);
    end
  endtask

  initial begin
    bus_if.Start     = 1'b0;
    bus_if.Op        = 2'b00;
    bus_if.A         = 32'd0;
    bus_if.B         = 32'd0;
    bus_if.ReadHiLo  = 1'b0;
    bus_if.WriteHi   = 1'b0;
    bus_if.WriteLo   = 1'b0;
    bus_if.WriteData = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_mthi_mtlo();
    test_stall_read();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
